// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with redirect, one-cycle flush and misaligned-target trap.
// Ports: clk, rst (async active-high); stall freezes RUN; jumpctrl/jalr_uc select branch/jalr target
// from imm and rs1_data; pc/pc_plus4 fetch address and link value; pc_valid, flush, trap status;
// epc holds the pc of the last trapping instruction; redirect_cnt counts accepted redirects.
// Build option: define REDIRECT_CNT_EN to implement the saturating redirect counter (tied to 0 otherwise).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jumpctrl,
  input  logic        jalr_uc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        flush,
  output logic        trap,
  output logic [31:0] epc,
  output logic [31:0] redirect_cnt
);
  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] TRAP  = 2'd3;
  logic [1:0]  state;
  logic [31:0] tgt;
  logic        redir;
  logic        mis;
  // redirect is only acted on in an unstalled RUN cycle
  logic        take;
  always_comb begin
    tgt   = jalr_uc ? ((rs1_data + imm) & ~32'h1) : pc + imm;
    redir = jalr_uc | jumpctrl;
    mis   = |tgt[1:0];
    take  = (state == RUN) & ~stall & redir;
  end
  assign pc_plus4 = pc + 32'd4;
  assign pc_valid = state == RUN;
  assign flush    = (state == FLUSH) | (state == TRAP);
  assign trap     = state == TRAP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      epc   <= 32'h0;
    end else if (state != RUN) begin
      state <= RUN;
    end else if (!stall) begin
      if (!redir) begin
        pc <= pc_plus4;
      end else if (mis) begin
        epc   <= pc;
        pc    <= TRAP_PC;
        state <= TRAP;
      end else begin
        pc    <= tgt;
        state <= FLUSH;
      end
    end
  end
`ifdef REDIRECT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) redirect_cnt <= 32'h0;
    else if (take && !mis && redirect_cnt != 32'hFFFF_FFFF) redirect_cnt <= redirect_cnt + 32'd1;
  end
`else
  assign redirect_cnt = 32'h0;
`endif
endmodule
